// File: rtl/lsu_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared size encodings, FSM states and lane-mask helpers for the LSU.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Lane mask for an access of 2^size bytes starting at byte lane 'offset'.
    function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] lanes;
        case (size)
            SZ_B:    lanes = 8'h01;
            SZ_H:    lanes = 8'h03;
            SZ_W:    lanes = 8'h0F;
            default: lanes = 8'hFF;
        endcase
        return lanes << offset;
    endfunction

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] low_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational lane steering: byte enables, store shift, load extract.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]                      i_size,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] i_offset,
    input  logic                            i_unsigned,
    input  logic [DATA_WIDTH-1:0]           i_wdata,
    input  logic [DATA_WIDTH-1:0]           i_rdata,
    output logic [DATA_WIDTH/8-1:0]         o_byte_enable,
    output logic [DATA_WIDTH-1:0]           o_wdata,
    output logic [DATA_WIDTH-1:0]           o_load_data
);

    localparam int c_bytes = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_field_mask;
    logic [DATA_WIDTH-1:0] w_fill;
    logic                  w_sign;

    assign o_byte_enable = c_bytes'(be_mask(i_size, 3'(i_offset)));
    assign o_wdata       = i_wdata << {i_offset, 3'b000};
    assign w_shifted     = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        w_field_mask = '1;
        w_sign       = w_shifted[DATA_WIDTH-1];
        case (i_size)
            SZ_B: begin
                w_field_mask = DATA_WIDTH'(8'hFF);
                w_sign       = w_shifted[7];
            end
            SZ_H: begin
                w_field_mask = DATA_WIDTH'(16'hFFFF);
                w_sign       = w_shifted[15];
            end
            SZ_W: begin
                w_field_mask = DATA_WIDTH'(32'hFFFF_FFFF);
                w_sign       = w_shifted[31];
            end
            default: begin
                w_field_mask = '1;
                w_sign       = w_shifted[DATA_WIDTH-1];
            end
        endcase
    end

    assign w_fill      = i_unsigned ? '0 : {DATA_WIDTH{w_sign}};
    assign o_load_data = (w_shifted & w_field_mask) | (w_fill & ~w_field_mask);

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : lsu_ctrl
// Purpose  : Single-outstanding load/store controller between execute and D-cache.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_req,
    output logic                    mem_ready,
    input  logic                    mem_we,
    input  logic [1:0]              mem_size,
    input  logic                    mem_unsigned,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic                    mem_valid,
    output logic                    mem_misaligned,
    output logic                    mem_timeout,
    output logic [DATA_WIDTH-1:0]   result_data,
    output logic                    data_req,
    input  logic                    data_gnt,
    output logic [ADDR_WIDTH-1:0]   data_addr,
    output logic                    data_we,
    output logic [DATA_WIDTH/8-1:0] byte_enable,
    output logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    data_valid,
    input  logic [DATA_WIDTH-1:0]   rdata
);

    localparam int c_bytes = DATA_WIDTH / 8;
    localparam int c_ofs   = $clog2(c_bytes);
    localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    lsu_state_e r_state, w_next;

    logic                     r_we;
    logic [1:0]               r_size;
    logic                     r_unsigned;
    logic [ADDR_WIDTH-1:c_ofs] r_addr_hi;
    logic [c_ofs-1:0]         r_offset;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [c_cnt_w-1:0]       r_cnt;
    logic                     r_misaligned;
    logic                     r_timeout;
    logic [DATA_WIDTH-1:0]    r_result;

    logic                     w_accept;
    logic                     w_err;
    logic                     w_active;
    logic                     w_to_hit;
    logic                     w_take;
    logic                     w_to;
    logic [c_bytes-1:0]       w_be;
    logic [DATA_WIDTH-1:0]    w_wdata;
    logic [DATA_WIDTH-1:0]    w_load;

    assign mem_ready = (r_state == ST_IDLE) || (r_state == ST_RESP);
    assign w_accept  = mem_req && mem_ready;
    assign w_active  = (r_state == ST_REQ) || (r_state == ST_WAIT);

    // Doubleword accesses only exist on a 64-bit bus; otherwise they fault like misalignment.
    assign w_err = (|(mem_addr[2:0] & low_mask(mem_size))) ||
                   ((mem_size == SZ_D) && (c_bytes < 8));

    assign w_to_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == c_cnt_w'(TIMEOUT_CYCLES));

    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        w_to   = 1'b0;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    w_next = w_err ? ST_RESP : ST_REQ;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (data_gnt && data_valid) begin
                    w_next = ST_RESP;
                    w_take = 1'b1;
                end else if (w_to_hit) begin
                    w_next = ST_RESP;
                    w_to   = 1'b1;
                end else if (data_gnt) begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (data_valid) begin
                    w_next = ST_RESP;
                    w_take = 1'b1;
                end else if (w_to_hit) begin
                    w_next = ST_RESP;
                    w_to   = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Completion flags and load data are only non-zero on the cycle entering RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we         <= 1'b0;
            r_size       <= SZ_B;
            r_unsigned   <= 1'b0;
            r_addr_hi    <= '0;
            r_offset     <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_misaligned <= 1'b0;
            r_timeout    <= 1'b0;
            r_result     <= '0;
        end else begin
            r_misaligned <= w_accept && w_err;
            r_timeout    <= w_to;
            r_result     <= (w_take && !r_we) ? w_load : '0;
            if (w_accept) begin
                r_we       <= mem_we;
                r_size     <= mem_size;
                r_unsigned <= mem_unsigned;
                r_addr_hi  <= mem_addr[ADDR_WIDTH-1:c_ofs];
                r_offset   <= mem_addr[c_ofs-1:0];
                r_wdata    <= mem_wdata;
                r_cnt      <= '0;
            end else if (w_active) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .i_size        (r_size),
        .i_offset      (r_offset),
        .i_unsigned    (r_unsigned),
        .i_wdata       (r_wdata),
        .i_rdata       (rdata),
        .o_byte_enable (w_be),
        .o_wdata       (w_wdata),
        .o_load_data   (w_load)
    );

    assign mem_valid      = (r_state == ST_RESP);
    assign mem_misaligned = r_misaligned;
    assign mem_timeout    = r_timeout;
    assign result_data    = r_result;
    assign data_req       = (r_state == ST_REQ);
    assign data_addr      = {r_addr_hi, {c_ofs{1'b0}}};
    assign data_we        = r_we && w_active;
    assign byte_enable    = w_active ? w_be : '0;
    assign wdata          = w_active ? w_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_lsu_ctrl
// Purpose  : Self-checking bench for lsu_ctrl, 32-bit (short timeout) and 64-bit builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        mem_req = 1'b0, mem_we = 1'b0, mem_unsigned = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic [31:0] mem_addr = '0;
    logic [63:0] mem_wdata = '0, rdata = '0;
    logic        data_gnt = 1'b0, data_valid = 1'b0;

    logic        rdy32, vld32, mis32, to32, dreq32, dwe32;
    logic [31:0] res32, daddr32, wd32;
    logic [3:0]  be32;
    logic        rdy64, vld64, mis64, to64, dreq64, dwe64;
    logic [63:0] res64, wd64;
    logic [31:0] daddr64;
    logic [7:0]  be64;

    logic        req32, gnt32, dv32, req64, gnt64, dv64;
    assign req32 = mem_req & ~sel;
    assign gnt32 = data_gnt & ~sel;
    assign dv32  = data_valid & ~sel;
    assign req64 = mem_req & sel;
    assign gnt64 = data_gnt & sel;
    assign dv64  = data_valid & sel;

    lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) u_dut32 (
        .clk(clk), .rst(rst), .mem_req(req32), .mem_ready(rdy32), .mem_we(mem_we),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata[31:0]), .mem_valid(vld32), .mem_misaligned(mis32),
        .mem_timeout(to32), .result_data(res32), .data_req(dreq32), .data_gnt(gnt32),
        .data_addr(daddr32), .data_we(dwe32), .byte_enable(be32), .wdata(wd32),
        .data_valid(dv32), .rdata(rdata[31:0])
    );

    lsu_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(255)) u_dut64 (
        .clk(clk), .rst(rst), .mem_req(req64), .mem_ready(rdy64), .mem_we(mem_we),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_valid(vld64), .mem_misaligned(mis64),
        .mem_timeout(to64), .result_data(res64), .data_req(dreq64), .data_gnt(gnt64),
        .data_addr(daddr64), .data_we(dwe64), .byte_enable(be64), .wdata(wd64),
        .data_valid(dv64), .rdata(rdata)
    );

    logic        o_ready, o_valid, o_mis, o_to, o_dreq, o_dwe;
    logic [63:0] o_result, o_wdata;
    logic [31:0] o_daddr;
    logic [7:0]  o_be;
    assign o_ready  = sel ? rdy64 : rdy32;
    assign o_valid  = sel ? vld64 : vld32;
    assign o_mis    = sel ? mis64 : mis32;
    assign o_to     = sel ? to64 : to32;
    assign o_dreq   = sel ? dreq64 : dreq32;
    assign o_dwe    = sel ? dwe64 : dwe32;
    assign o_result = sel ? res64 : {32'h0, res32};
    assign o_wdata  = sel ? wd64 : {32'h0, wd32};
    assign o_daddr  = sel ? daddr64 : daddr32;
    assign o_be     = sel ? be64 : {4'h0, be32};

    typedef struct packed {
        logic        mis;
        logic        to;
        logic [63:0] res;
    } exp_t;

    exp_t sb[$];
    exp_t e_pop;
    int   n_chk = 0;
    int   n_err = 0;

    // Drive one operation at a non-edge time; it is accepted on the next rising edge.
    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [63:0] wd,
                        input bit track, input exp_t ex);
        mem_we = we; mem_size = sz; mem_unsigned = uns; mem_addr = addr; mem_wdata = wd;
        mem_req = 1'b1;
        if (track) sb.push_back(ex);
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        n_chk++;
        if (o_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready got=%b want=1", o_ready);
        end
        n_chk++;
        if ({o_valid, o_mis, o_to, o_dreq, o_dwe} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl got=%b want=00000", {o_valid, o_mis, o_to, o_dreq, o_dwe});
        end
        n_chk++;
        if ({o_result, o_daddr, o_be, o_wdata} !== '0) begin
            n_err++; $display("FAIL reset_data got res=%h addr=%h be=%h wd=%h want all 0", o_result, o_daddr, o_be, o_wdata);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lb();
        exp_t ex;
        for (int u = 0; u < 2; u++) begin
            ex = '{1'b0, 1'b0, (u == 1) ? 64'h0000_0080 : 64'hFFFF_FF80};
            send(1'b0, SZ_B, u[0], 32'h1003, 64'h0, 1'b1, ex);
            @(negedge clk);
            n_chk++;
            if (o_dreq !== 1'b1 || o_be !== 8'h08 || o_daddr !== 32'h1000 || o_dwe !== 1'b0) begin
                n_err++; $display("FAIL lb_request got req=%b be=%h addr=%h we=%b want 1 08 00001000 0", o_dreq, o_be, o_daddr, o_dwe);
            end
            data_gnt = 1'b1; data_valid = 1'b1; rdata = 64'h80AA_BBCC;
            @(posedge clk); #1;
            data_gnt = 1'b0; data_valid = 1'b0;
            @(negedge clk);
            e_pop = sb.pop_front();
            n_chk++;
            if ({o_valid, o_mis, o_to, o_result} !== {1'b1, e_pop}) begin
                n_err++; $display("FAIL lb_resp unsigned=%0d got v=%b mis=%b to=%b res=%h want v=1 mis=%b to=%b res=%h", u, o_valid, o_mis, o_to, o_result, e_pop.mis, e_pop.to, e_pop.res);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sh();
        exp_t ex;
        ex = '{1'b0, 1'b0, 64'h0};
        send(1'b1, SZ_H, 1'b0, 32'h2002, 64'h1234, 1'b1, ex);
        @(negedge clk);
        n_chk++;
        if (o_dreq !== 1'b1 || o_be !== 8'h0C || o_wdata !== 64'h1234_0000 || o_dwe !== 1'b1) begin
            n_err++; $display("FAIL sh_request got req=%b be=%h wd=%h we=%b want 1 0c 12340000 1", o_dreq, o_be, o_wdata, o_dwe);
        end
        data_gnt = 1'b1;
        @(posedge clk); #1;
        data_gnt = 1'b0;
        @(negedge clk);
        n_chk++;
        if (o_dreq !== 1'b0 || o_valid !== 1'b0) begin
            n_err++; $display("FAIL sh_wait got req=%b valid=%b want 0 0", o_dreq, o_valid);
        end
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        @(negedge clk);
        e_pop = sb.pop_front();
        n_chk++;
        if ({o_valid, o_mis, o_to, o_result} !== {1'b1, e_pop}) begin
            n_err++; $display("FAIL sh_resp got v=%b mis=%b to=%b res=%h want v=1 mis=0 to=0 res=0", o_valid, o_mis, o_to, o_result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_misaligned();
        exp_t ex;
        ex = '{1'b1, 1'b0, 64'h0};
        for (int i = 0; i < 2; i++) begin
            send(1'b0, (i == 0) ? SZ_W : SZ_D, 1'b0, (i == 0) ? 32'h3001 : 32'h3008, 64'h0, 1'b1, ex);
            @(negedge clk);
            e_pop = sb.pop_front();
            n_chk++;
            if ({o_valid, o_mis, o_to, o_result, o_dreq} !== {1'b1, e_pop, 1'b0}) begin
                n_err++; $display("FAIL misaligned_resp case=%0d got v=%b mis=%b to=%b res=%h req=%b want v=1 mis=1 to=0 res=0 req=0", i, o_valid, o_mis, o_to, o_result, o_dreq);
            end
            @(posedge clk); #1;
            @(negedge clk);
            n_chk++;
            if (o_dreq !== 1'b0 || o_valid !== 1'b0) begin
                n_err++; $display("FAIL misaligned_after case=%0d got req=%b valid=%b want 0 0", i, o_dreq, o_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        exp_t ex;
        int   lat;
        bit   got;
        ex = '{1'b0, 1'b1, 64'h0};
        send(1'b0, SZ_W, 1'b0, 32'h5000, 64'h0, 1'b1, ex);
        lat = 0; got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                got = 1'b1; lat = i;
            end else begin
                @(posedge clk); #1;
            end
        end
        n_chk++;
        if (!got || lat != 6) begin
            n_err++; $display("FAIL timeout_latency got=%0d want=6", got ? lat : -1);
        end
        e_pop = sb.pop_front();
        n_chk++;
        if ({o_mis, o_to, o_result} !== e_pop) begin
            n_err++; $display("FAIL timeout_resp got mis=%b to=%b res=%h want mis=0 to=1 res=0", o_mis, o_to, o_result);
        end
        data_valid = 1'b1; rdata = 64'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_chk++;
            if (o_valid !== 1'b0 || o_dreq !== 1'b0) begin
                n_err++; $display("FAIL late_resp cycle=%0d got valid=%b req=%b want 0 0", i, o_valid, o_dreq);
            end
        end
        data_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        exp_t ex;
        ex = '{1'b0, 1'b0, 64'h0};
        send(1'b0, SZ_W, 1'b0, 32'h6004, 64'h0, 1'b0, ex);
        @(negedge clk);
        data_gnt = 1'b1;
        @(posedge clk); #1;
        data_gnt = 1'b0;
        @(negedge clk);
        n_chk++;
        if (o_dreq !== 1'b0 || o_be !== 8'h0F || o_daddr !== 32'h6004) begin
            n_err++; $display("FAIL midop_wait got req=%b be=%h addr=%h want 0 0f 00006004", o_dreq, o_be, o_daddr);
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if ({o_dreq, o_dwe, o_valid, o_mis, o_to} !== 5'b0 || {o_be, o_wdata, o_daddr, o_result} !== '0 || o_ready !== 1'b1) begin
            n_err++; $display("FAIL midop_reset got req=%b be=%h addr=%h res=%h valid=%b ready=%b want 0 00 0 0 0 1", o_dreq, o_be, o_daddr, o_result, o_valid, o_ready);
        end
        #2 rst = 1'b1;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_chk++;
            if (o_valid !== 1'b0) begin
                n_err++; $display("FAIL midop_no_valid cycle=%0d got=%b want=0", i, o_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_grant_stall();
        exp_t ex;
        ex = '{1'b0, 1'b0, 64'h0};
        send(1'b1, SZ_B, 1'b0, 32'h15, 64'hAB, 1'b1, ex);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++;
            if (o_dreq !== 1'b1 || o_daddr !== 32'h10 || o_be !== 8'h20 || o_wdata !== 64'h0000_AB00_0000_0000) begin
                n_err++; $display("FAIL stall_hold cycle=%0d got req=%b addr=%h be=%h wd=%h want 1 00000010 20 0000ab0000000000", i, o_dreq, o_daddr, o_be, o_wdata);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        data_gnt = 1'b1; data_valid = 1'b1;
        @(posedge clk); #1;
        data_gnt = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        e_pop = sb.pop_front();
        n_chk++;
        if ({o_valid, o_mis, o_to, o_result} !== {1'b1, e_pop}) begin
            n_err++; $display("FAIL stall_resp got v=%b mis=%b to=%b res=%h want v=1 mis=0 to=0 res=0", o_valid, o_mis, o_to, o_result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t ex;
        ex = '{1'b0, 1'b0, 64'h8877_6655_4433_2211};
        send(1'b0, SZ_D, 1'b0, 32'h08, 64'h0, 1'b1, ex);
        @(negedge clk);
        n_chk++;
        if (o_dreq !== 1'b1 || o_be !== 8'hFF || o_daddr !== 32'h08) begin
            n_err++; $display("FAIL ld_request got req=%b be=%h addr=%h want 1 ff 00000008", o_dreq, o_be, o_daddr);
        end
        data_gnt = 1'b1; data_valid = 1'b1; rdata = 64'h8877_6655_4433_2211;
        @(posedge clk); #1;
        data_gnt = 1'b0; data_valid = 1'b0;
        ex = '{1'b0, 1'b0, 64'h0000_0000_F000_0000};
        mem_we = 1'b0; mem_size = SZ_W; mem_unsigned = 1'b1; mem_addr = 32'h0C; mem_req = 1'b1;
        sb.push_back(ex);
        @(negedge clk);
        e_pop = sb.pop_front();
        n_chk++;
        if ({o_valid, o_ready, o_mis, o_to, o_result} !== {2'b11, e_pop}) begin
            n_err++; $display("FAIL ld_resp got v=%b rdy=%b mis=%b to=%b res=%h want v=1 rdy=1 res=8877665544332211", o_valid, o_ready, o_mis, o_to, o_result);
        end
        @(posedge clk); #1;
        mem_req = 1'b0;
        @(negedge clk);
        n_chk++;
        if (o_dreq !== 1'b1 || o_be !== 8'hF0 || o_daddr !== 32'h08) begin
            n_err++; $display("FAIL lwu_request got req=%b be=%h addr=%h want 1 f0 00000008", o_dreq, o_be, o_daddr);
        end
        data_gnt = 1'b1; data_valid = 1'b1; rdata = 64'hF000_0000_0000_0000;
        @(posedge clk); #1;
        data_gnt = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        e_pop = sb.pop_front();
        n_chk++;
        if ({o_valid, o_mis, o_to, o_result} !== {1'b1, e_pop}) begin
            n_err++; $display("FAIL lwu_resp got v=%b mis=%b to=%b res=%h want v=1 res=00000000f0000000", o_valid, o_mis, o_to, o_result);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_misaligned();
        test_timeout();
        test_reset_midop();
        sel = 1'b1;
        test_grant_stall();
        test_back_to_back();
        n_chk++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL sb_drain pending=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
